ysyx_23060020_axil_reader: RTL
==============================

Name: ysyx_23060020_axil_reader

Overview:
- Single-outstanding AXI4-Lite read-channel master (AR/R only).
- Accepts one word-read request from a core-side producer (IFU or LSU load path) over a valid/ready handshake.
- Issues the bus read, captures the data word, and returns data plus a status code to the consumer over a second valid/ready handshake.
- Sits between pipeline stage logic and the memory/crossbar slave; it is the read-side counterpart to the core's write-enabled storage.

Parameters:
ADDR_W, 32, width of request address and araddr
DATA_W, 32, width of rdata/rsp_data; must be 32 (word access, 4-byte alignment)
PROT, 3'b000, constant value driven on arprot

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  byte address of word to read
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  read data; 0 on any error
rsp_err  out  2  status: 00 OK, 01 misaligned, 10 bus error
araddr  out  ADDR_W  AXI read address
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
arprot  out  3  AXI protection, fixed to PROT
rdata  in  DATA_W  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- Reset values: state=IDLE, arvalid=0, rready=0, rsp_valid=0, rsp_data=0, rsp_err=00, araddr=0, busy=0.
- All AXI and rsp outputs are registered, with no combinational path from inputs to outputs. The exception is req_ready, which is decoded from state as (state==IDLE).
- States: IDLE, AR, R, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid with req_addr[1:0]!=0: no bus access; next state RSP with rsp_err=01, rsp_data=0.
  - On req_valid with aligned address: latch araddr=req_addr; next state AR, with arvalid=1 from the next cycle.
- AR:
  - arvalid=1; araddr held stable.
  - On arready: arvalid drops next cycle, rready=1 next cycle, next state R.
  - arvalid is never withdrawn before the handshake, per AXI.
- R:
  - rready=1.
  - On rvalid, capture the response. If rresp[1]==0 (OKAY/EXOKAY): rsp_data=rdata, rsp_err=00. If rresp[1]==1 (SLVERR/DECERR): rsp_data=0, rsp_err=10.
  - rready drops next cycle; next state RSP.
  - No timeout: the block waits indefinitely.
- RSP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle; next state IDLE.
- Latency with zero-wait slave (arready=1, rvalid the cycle after the AR handshake):
  - req accepted at cycle t; arvalid high at t+1; rvalid at t+2; rsp_valid at t+3.
  - Next request is accepted at t+4 at the earliest, since req_ready is high only in IDLE (no overlap).
- Misaligned latency: request at t gives rsp_valid at t+1.
- Only one transaction is outstanding. A new req_valid while busy is ignored (req_ready=0) and the producer must hold it.
- rvalid or arready asserted in a state where the block is not waiting for it: ignored, no state change.
- Reset mid-operation: next edge returns to IDLE with arvalid/rready deasserted. The in-flight AXI transaction is abandoned; the system reset must also reset the slave.
- rsp_err encoding 11 is reserved and never driven.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, AR=2'd1, R=2'd2, RSP=2'd3;
  - rsp_err codes: ERR_OK, ERR_MISALIGN, ERR_BUS;
  - AXI rresp constants: OKAY, EXOKAY, SLVERR, DECERR.
- No sub-module: single FSM plus address/data/status capture registers in one module.

Test Plan:
- Zero-wait read: req_addr=0x80000000, slave returns rdata=0xDEADBEEF, rresp=00 -> arvalid at t+1 with araddr=0x80000000, rsp_valid at t+3, rsp_data=0xDEADBEEF, rsp_err=00.
- Stalled slave: arready low 3 cycles, rvalid delayed 5 cycles -> arvalid/araddr stable throughout, rready high only in R, single rsp with correct data, busy=1 until rsp handshake.
- Misaligned: req_addr=0x80000002 -> no arvalid ever, rsp_valid at t+1, rsp_err=01, rsp_data=0.
- Bus error: rresp=2'b10 with rdata=0x12345678 -> rsp_err=10, rsp_data=0; rresp=2'b11 gives the same.
- Backpressure: rsp_ready held low 4 cycles, second req_valid asserted meanwhile -> rsp fields stable, req_ready=0 until the cycle after the rsp handshake, second request then served correctly.
- Reset in R state: rst pulsed while rready=1 -> next cycle state IDLE, arvalid=0, rready=0, rsp_valid=0, req_ready=1.

Source files
------------

// File: rtl/ysyx_23060020_axil_reader_pkg.sv
// Shared types and constants for the AXI4-Lite read master.
package ysyx_23060020_axil_reader_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RSP  = 2'd3
  } state_t;

  // Status codes returned to the consumer (2'b11 reserved, never driven)
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS      = 2'b10;

  // AXI read response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060020_axil_reader.sv
// Single-outstanding AXI4-Lite read master: one word read per request,
// result and status returned over a valid/ready response handshake.
module ysyx_23060020_axil_reader
  import ysyx_23060020_axil_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [2:0]        arprot,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy
);

  state_t state;

  // Decoded from the state register only; no input-to-output path.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign arprot    = PROT;

  // Transaction FSM with registered AXI and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_addr[1:0] != 2'b00) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= ERR_MISALIGN;
              state     <= RSP;
            end else begin
              araddr  <= req_addr;
              arvalid <= 1'b1;
              state   <= AR;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
            if (rresp == SLVERR || rresp == DECERR) begin
              rsp_data <= '0;
              rsp_err  <= ERR_BUS;
            end else begin
              rsp_data <= rdata;
              rsp_err  <= ERR_OK;
            end
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
